// File: rtl/rm0_stream_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rm0_stream_bridge                                                      |
// | Wishbone master shuttling J1B virtual-UART bytes to/from RM0 registers.|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+

module rm0_stream_bridge_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end
endmodule

module rm0_stream_bridge #(
  parameter logic [27:0] RM0_BASE_ADR  = 28'h0,
  parameter int          FIFO_DEPTH    = 16,
  parameter int          POLL_INTERVAL = 64,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        enable,
  output logic [27:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  output logic        wbm_cyc_o,
  input  logic        wbm_err_i,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_flag,
  input  logic        err_clr
);
  localparam logic [27:0] TX_ADR = RM0_BASE_ADR + 28'd8210;
  localparam logic [27:0] RX_ADR = RM0_BASE_ADR + 28'd8208;
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] POLL_ONE    = PW'(1);
  localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] ACK_ONE     = TW'(1);

  typedef enum logic [1:0] {IDLE, RD_TX, RD_RXST, WR_RX} state_t;

  state_t        state;
  logic [PW-1:0] poll_timer;
  logic [TW-1:0] ack_timer;
  logic          last_tx;
  logic          in_full, in_empty, out_full, out_empty;
  logic [7:0]    in_head;
  logic          timeout, bus_fail, bus_ack;
  logic          tx_elig, rx_elig, tx_push, rx_pop;
  logic          unused_dat;

  assign unused_dat = ^wbm_dat_i[31:9];

  // ack_timer only advances once stb has dropped, i.e. after acceptance
  assign timeout  = wbm_cyc_o && !wbm_stb_o && (ack_timer == ACK_LAST);
  assign bus_fail = wbm_cyc_o && (wbm_err_i || (timeout && !wbm_ack_i));
  assign bus_ack  = wbm_cyc_o && wbm_ack_i && !wbm_err_i;
  assign tx_elig  = enable && (poll_timer == '0) && !out_full;
  assign rx_elig  = enable && !in_empty;
  assign tx_push  = (state == RD_TX) && bus_ack && wbm_dat_i[8];
  assign rx_pop   = (state == WR_RX) && bus_ack;
  assign in_ready  = !in_full;
  assign out_valid = !out_empty;

  rm0_stream_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(sys_clk), .rst(rst), .push(in_valid), .push_data(in_data),
    .pop(rx_pop), .head(in_head), .full(in_full), .empty(in_empty)
  );

  rm0_stream_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(sys_clk), .rst(rst), .push(tx_push), .push_data(wbm_dat_i[7:0]),
    .pop(out_ready), .head(out_data), .full(out_full), .empty(out_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '0;
      poll_timer <= POLL_RELOAD;
      ack_timer  <= '0;
      last_tx    <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      if (poll_timer != '0) poll_timer <= poll_timer - POLL_ONE;
      if (err_clr) err_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_elig || rx_elig) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_dat_o <= '0;
            wbm_sel_o <= 4'hF;
          end
          // Round-robin: TX wins a tie only if RX was served last
          if (tx_elig && (!rx_elig || !last_tx)) begin
            state     <= RD_TX;
            last_tx   <= 1'b1;
            wbm_adr_o <= TX_ADR;
          end else if (rx_elig) begin
            state     <= RD_RXST;
            last_tx   <= 1'b0;
            wbm_adr_o <= RX_ADR;
          end
        end
        default: begin
          if (wbm_stb_o) ack_timer <= '0;
          else           ack_timer <= ack_timer + ACK_ONE;
          if (wbm_stb_o && !wbm_stall_i) wbm_stb_o <= 1'b0;
          if (bus_fail) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            err_flag  <= 1'b1;
          end else if (bus_ack) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (state == RD_TX) poll_timer <= POLL_RELOAD;
            if (state == RD_RXST && !wbm_dat_i[8]) begin
              state     <= WR_RX;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_dat_o <= {24'b0, in_head};
            end
          end
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_rm0_stream_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rm0_stream_bridge                                                   |
// | Scoreboard bench with an RM0-like Wishbone slave model.                |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+

module tb_rm0_stream_bridge;
  localparam int P = 8;
  localparam int T = 10;
  localparam int D = 16;
  localparam logic [27:0] BASE = 28'h0040000;
  localparam logic [27:0] TX_A = 28'h0042012;
  localparam logic [27:0] RX_A = 28'h0042010;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [27:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        wbm_stall_i;
  logic        wbm_cyc_o;
  logic        wbm_err_i;
  logic [7:0]  in_data = 8'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err_flag;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_bytes[$];
  logic [35:0] exp_wr[$];
  logic [7:0]  tx_q[$];

  int edge_n = 0;
  int waiting = 0, in_txn = 0, stall_left = 0, stall_next = 0, cur_stalled = 0;
  int stb_len = 0, stalled_len = 0, adr_moves = 0;
  int noack_next = 0, noack_active = 0, noack_acc = 0, fall_edge = -1;
  int err_on_write = 0, tx_reads = 0, rxst_reads = 0, tx_ack_edge = -1;
  logic        rx_avl = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic [27:0] stb_adr = '0;
  logic        resp_err = 1'b0, resp_tx_push = 1'b0;
  logic [31:0] resp_dat = '0;

  rm0_stream_bridge #(
    .RM0_BASE_ADR(BASE), .FIFO_DEPTH(D), .POLL_INTERVAL(P), .ACK_TIMEOUT(T)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i), .wbm_cyc_o(wbm_cyc_o),
    .wbm_err_i(wbm_err_i),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_flag(err_flag), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    edge_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic accept();
    logic [35:0] e;
    resp_err = 1'b0;
    resp_dat = '0;
    resp_tx_push = 1'b0;
    if (!wbm_we_o) begin
      chk("rd_sel", {28'h0, wbm_sel_o}, 32'hF);
      chk("rd_dat", wbm_dat_o, 32'h0);
    end
    if (noack_next != 0) begin
      noack_next = 0;
      noack_active = 1;
      noack_acc = edge_n + 1;
    end else if (wbm_we_o) begin
      if (exp_wr.size() == 0) fail("unexpected_write");
      else begin
        e = exp_wr.pop_front();
        chk("wr_adr", {4'h0, wbm_adr_o}, {4'h0, e[35:8]});
        chk("wr_dat", wbm_dat_o, {24'h0, e[7:0]});
        chk("wr_sel", {28'h0, wbm_sel_o}, 32'hF);
      end
      if (err_on_write != 0) begin
        err_on_write = 0;
        resp_err = 1'b1;
      end else begin
        rx_data = wbm_dat_o[7:0];
        rx_avl = 1'b1;
      end
    end else if (wbm_adr_o == TX_A) begin
      tx_reads++;
      if (tx_q.size() > 0) begin
        resp_dat = {23'h0, 1'b1, tx_q.pop_front()};
        resp_tx_push = 1'b1;
      end
    end else if (wbm_adr_o == RX_A) begin
      rxst_reads++;
      resp_dat = {23'h0, rx_avl, rx_data};
    end else begin
      fail("bad_read_adr");
    end
  endtask

  // RM0-like slave: optional stall, ack one cycle after acceptance
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0; wbm_dat_i = '0;
    forever begin
      @(negedge sys_clk);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0; wbm_dat_i = '0;
      if (rst || !wbm_cyc_o) begin
        if (waiting != 0 && noack_active != 0) fall_edge = edge_n;
        waiting = 0; noack_active = 0; in_txn = 0;
      end else if (wbm_stb_o && waiting == 0) begin
        if (in_txn == 0) begin
          in_txn = 1; stb_len = 0; stb_adr = wbm_adr_o;
          stall_left = stall_next; cur_stalled = (stall_next > 0) ? 1 : 0; stall_next = 0;
        end
        stb_len++;
        if (wbm_adr_o !== stb_adr) adr_moves++;
        if (stall_left > 0) begin
          wbm_stall_i = 1'b1;
          stall_left--;
        end else begin
          in_txn = 0; waiting = 1;
          if (cur_stalled != 0) stalled_len = stb_len;
          accept();
        end
      end else if (waiting != 0 && noack_active == 0) begin
        waiting = 0;
        if (resp_err) wbm_err_i = 1'b1;
        else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = resp_dat;
          if (resp_tx_push) tx_ack_edge = edge_n + 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_bytes.size() == 0) fail("unexpected_out_byte");
      else chk("out_byte", {24'h0, out_data}, {24'h0, exp_bytes.pop_front()});
    end
  end

  task automatic send(input logic [7:0] b);
    chk("in_ready", {31'h0, in_ready}, 32'h1);
    in_data = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_rx();
    int n = 0;
    while (!rx_avl && n < 200) begin tick(); n++; end
    chk("rx_written", {31'h0, rx_avl}, 32'h1);
  endtask

  initial begin
    int n, rel, f, r, r0;
    repeat (3) tick();
    chk("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
    chk("rst_we", {31'h0, wbm_we_o}, 32'h0);
    chk("rst_adr", {4'h0, wbm_adr_o}, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_sel", {28'h0, wbm_sel_o}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_err_flag", {31'h0, err_flag}, 32'h0);
    rst = 1'b0;
    rel = edge_n;

    // First poll timing, then an idle poll (busy=0)
    n = 0; while (!wbm_stb_o && n < 100) begin tick(); n++; end
    chk("first_poll_edge", edge_n - rel, P);
    chk("first_poll_adr", {4'h0, wbm_adr_o}, {4'h0, TX_A});
    n = 0; while (wbm_cyc_o && n < 50) begin tick(); n++; end
    f = edge_n;
    n = 0; while (!wbm_stb_o && n < 100) begin tick(); n++; end
    chk("poll_interval", edge_n - f, P);
    chk("no_push_on_idle", {31'h0, out_valid}, 32'h0);

    // TX byte 0x1A5 -> out 0xA5
    out_ready = 1'b0;
    tx_q.push_back(8'hA5); exp_bytes.push_back(8'hA5);
    n = 0; while (!out_valid && n < 100) begin tick(); n++; end
    chk("tx_valid", {31'h0, out_valid}, 32'h1);
    chk("tx_data", {24'h0, out_data}, 32'hA5);
    chk("tx_latency", edge_n, tx_ack_edge);
    out_ready = 1'b1;
    repeat (2) tick();

    // RX byte with slot empty, then with slot occupied (retry)
    exp_wr.push_back({RX_A, 8'h3C});
    send(8'h3C);
    wait_rx();
    chk("rx_data_3c", {24'h0, rx_data}, 32'h3C);
    send(8'h5A);
    r0 = rxst_reads;
    repeat (40) tick();
    chk("rx_retry_polls", {31'h0, (rxst_reads - r0) >= 2}, 32'h1);
    exp_wr.push_back({RX_A, 8'h5A});
    rx_avl = 1'b0;
    wait_rx();
    chk("rx_data_5a", {24'h0, rx_data}, 32'h5A);

    // Stall 3 cycles on a TX poll
    stalled_len = 0; stall_next = 3;
    tx_q.push_back(8'hC3); exp_bytes.push_back(8'hC3);
    n = 0; while (stalled_len == 0 && n < 100) begin tick(); n++; end
    chk("stall_stb_len", stalled_len, 4);
    chk("stall_adr_stable", adr_moves, 0);
    n = 0; while (exp_bytes.size() != 0 && n < 100) begin tick(); n++; end
    chk("stall_one_push", exp_bytes.size(), 0);

    // Bus error on WR_RX: byte retained and retried
    rx_avl = 1'b0; err_on_write = 1;
    exp_wr.push_back({RX_A, 8'h77}); exp_wr.push_back({RX_A, 8'h77});
    send(8'h77);
    n = 0; while (!err_flag && n < 100) begin tick(); n++; end
    chk("err_on_write", {31'h0, err_flag}, 32'h1);
    wait_rx();
    chk("rx_data_77", {24'h0, rx_data}, 32'h77);
    chk("err_sticky", {31'h0, err_flag}, 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", {31'h0, err_flag}, 32'h0);

    // Missing ack -> timeout
    fall_edge = -1; noack_next = 1;
    n = 0; while (!err_flag && n < 200) begin tick(); n++; end
    chk("timeout_err", {31'h0, err_flag}, 32'h1);
    chk("timeout_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    chk("timeout_edges", fall_edge - noack_acc, T);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr2", {31'h0, err_flag}, 32'h0);

    // Fill output FIFO; polls stop, RX still flows; one pop resumes polling
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      tx_q.push_back(8'h40 + 8'(i)); exp_bytes.push_back(8'h40 + 8'(i));
    end
    n = 0; while (tx_q.size() != 0 && n < 400) begin tick(); n++; end
    repeat (5) tick();
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    r = tx_reads;
    rx_avl = 1'b0;
    exp_wr.push_back({RX_A, 8'h99});
    send(8'h99);
    wait_rx();
    chk("rx_data_99", {24'h0, rx_data}, 32'h99);
    repeat (40) tick();
    chk("no_poll_when_full", tx_reads, r);
    tx_q.push_back(8'h50); exp_bytes.push_back(8'h50);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n = 0; while (tx_reads == r && n < 50) begin tick(); n++; end
    chk("poll_resumes", {31'h0, tx_reads != r}, 32'h1);
    out_ready = 1'b1;
    n = 0; while (exp_bytes.size() != 0 && n < 300) begin tick(); n++; end
    repeat (5) tick();

    chk("exp_bytes_empty", exp_bytes.size(), 0);
    chk("exp_wr_empty", exp_wr.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000ns");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
